// File: rtl/lsu_bus_adapter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | basic_cache_params / lsu_bus_pkg                                 |
// | Cache geometry, LSU bus adapter types and PMA constants.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package basic_cache_params;
  localparam int aligned_addr_size = 16;
endpackage

package lsu_bus_pkg;
  localparam int XLEN          = 64;
  localparam int MASK_W        = XLEN / 8;
  localparam int AADDR_W       = basic_cache_params::aligned_addr_size;
  localparam int PMA_BASE_LINE = 0;
  localparam int PMA_LINES     = 2 ** (AADDR_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic                we;
    logic [AADDR_W-1:0]  addr;
    logic [XLEN-1:0]     wdata;
    logic [MASK_W-1:0]   wmask;
  } bus_req_t;
endpackage
`default_nettype wire

// File: rtl/lsu_bus_adapter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_bus_adapter_if                                               |
// | LSU request/response and cache-bus signals of the adapter.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface lsu_bus_adapter_if;
  import lsu_bus_pkg::*;

  logic               lsu_prev_stalled;
  logic               lsu_stall_next;
  logic [AADDR_W-1:0] lsu_addr;
  logic               lsu_do_load;
  logic               lsu_do_store;
  logic [XLEN-1:0]    lsu_store_data;
  logic [MASK_W-1:0]  lsu_store_mask;
  logic [XLEN-1:0]    lsu_load_data;
  logic               lsu_access_fault;

  logic               bus_req;
  logic               bus_we;
  logic [AADDR_W-1:0] bus_addr;
  logic [XLEN-1:0]    bus_wdata;
  logic [MASK_W-1:0]  bus_wmask;
  logic               bus_ready;
  logic               bus_resp_valid;
  logic               bus_resp_err;
  logic [XLEN-1:0]    bus_resp_data;

  modport slave (
    input  lsu_prev_stalled, lsu_addr, lsu_do_load, lsu_do_store,
           lsu_store_data, lsu_store_mask,
           bus_ready, bus_resp_valid, bus_resp_err, bus_resp_data,
    output lsu_stall_next, lsu_load_data, lsu_access_fault,
           bus_req, bus_we, bus_addr, bus_wdata, bus_wmask
  );

  modport master (
    output lsu_prev_stalled, lsu_addr, lsu_do_load, lsu_do_store,
           lsu_store_data, lsu_store_mask,
           bus_ready, bus_resp_valid, bus_resp_err, bus_resp_data,
    input  lsu_stall_next, lsu_load_data, lsu_access_fault,
           bus_req, bus_we, bus_addr, bus_wdata, bus_wmask
  );
endinterface
`default_nettype wire

// File: rtl/lsu_bus_adapter_pma_check.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_pma_check                                                    |
// | Combinational physical-memory range check on a line address.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module lsu_pma_check #(
  parameter int AADDR_W       = 16,
  parameter int MEM_BASE_LINE = 0,
  parameter int MEM_LINES     = 2 ** (AADDR_W - 1)
) (
  input  logic [AADDR_W-1:0] addr_i,
  output logic               in_range_o
);
  localparam logic [AADDR_W:0] c_BASE  = (AADDR_W + 1)'(MEM_BASE_LINE);
  localparam logic [AADDR_W:0] c_LINES = (AADDR_W + 1)'(MEM_LINES);

  logic [AADDR_W:0] w_offset;

  // Addresses below the base wrap to an offset of at least 2**AADDR_W,
  // which is never below c_LINES, so one compare covers both bounds.
  assign w_offset   = {1'b0, addr_i} - c_BASE;
  assign in_range_o = (w_offset < c_LINES);
endmodule
`default_nettype wire

// File: rtl/lsu_bus_adapter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_bus_adapter                                                  |
// | Runs one LSU line load/store per transaction on the cache bus.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module lsu_bus_adapter
  import lsu_bus_pkg::*;
#(
  parameter int MEM_BASE_LINE = PMA_BASE_LINE,
  parameter int MEM_LINES     = PMA_LINES
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  lsu_bus_adapter_if.slave bus_if
);
  lsu_state_e      state_q, state_d;
  bus_req_t        req_q, req_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            fault_q, fault_d;

  logic            w_in_range;
  logic [XLEN-1:0] w_resp_data;

  lsu_pma_check #(
    .AADDR_W       (AADDR_W),
    .MEM_BASE_LINE (MEM_BASE_LINE),
    .MEM_LINES     (MEM_LINES)
  ) u_pma (
    .addr_i     (bus_if.lsu_addr),
    .in_range_o (w_in_range)
  );

  // Stores and errored reads return a zero line word.
  assign w_resp_data = (!req_q.we && !bus_if.bus_resp_err) ? bus_if.bus_resp_data : '0;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (!bus_if.lsu_prev_stalled) begin
          req_d   = '{we:    bus_if.lsu_do_store,
                      addr:  bus_if.lsu_addr,
                      wdata: bus_if.lsu_store_data,
                      wmask: bus_if.lsu_store_mask};
          data_d  = '0;
          fault_d = 1'b0;
          if (!w_in_range) begin
            fault_d = 1'b1;
            state_d = S_RESP;
          end else if (bus_if.lsu_do_store && (bus_if.lsu_store_mask == '0)) begin
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (bus_if.bus_ready) begin
          if (bus_if.bus_resp_valid) begin
            data_d  = w_resp_data;
            fault_d = bus_if.bus_resp_err;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus_if.bus_resp_valid) begin
          data_d  = w_resp_data;
          fault_d = bus_if.bus_resp_err;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      fault_q <= fault_d;
    end
  end

  // bus_req decodes the state register so reset removes it without a clock.
  assign bus_if.bus_req          = (state_q == S_ISSUE);
  assign bus_if.bus_we           = req_q.we;
  assign bus_if.bus_addr         = req_q.addr;
  assign bus_if.bus_wdata        = req_q.wdata;
  assign bus_if.bus_wmask        = req_q.wmask;
  assign bus_if.lsu_stall_next   = (state_q != S_RESP);
  assign bus_if.lsu_load_data    = data_q;
  assign bus_if.lsu_access_fault = fault_q;
endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_adapter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_lsu_bus_adapter                                               |
// | Scoreboard bench for lsu_bus_adapter.                            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_lsu_bus_adapter;
  import lsu_bus_pkg::*;

  typedef struct {
    logic [XLEN-1:0] data;
    logic            fault;
    int              lat;
    int              reqs;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  lsu_bus_adapter_if bif();

  lsu_bus_adapter dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_if (bif)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Reference model: pushes the expected response for one request.
  task automatic push_exp(input logic [AADDR_W-1:0] addr, input logic st,
                          input logic [MASK_W-1:0] wm, input int rdy, input int rsp,
                          input logic err, input logic [XLEN-1:0] rdata);
    exp_t e;
    int   a;
    a = int'(addr);
    if (a < PMA_BASE_LINE || a >= PMA_BASE_LINE + PMA_LINES)
      e = '{data: '0, fault: 1'b1, lat: 1, reqs: 0};
    else if (st && wm == '0)
      e = '{data: '0, fault: 1'b0, lat: 1, reqs: 0};
    else
      e = '{data: (st || err) ? '0 : rdata, fault: err, lat: rdy + rsp + 2, reqs: rdy + 1};
    sb.push_back(e);
  endtask

  // Requester plus bus responder; measures, does not judge.
  task automatic run_req(input logic [AADDR_W-1:0] addr, input logic ld, input logic st,
                         input logic [XLEN-1:0] wd, input logic [MASK_W-1:0] wm,
                         input int rdy_dly, input int rsp_dly, input logic err,
                         input logic [XLEN-1:0] rdata,
                         output int lat, output logic [XLEN-1:0] odata, output logic ofault,
                         output int req_cyc, output int stall_cyc, output bit stable,
                         output bus_req_t obs);
    int pending;
    bit done;
    bif.lsu_addr         = addr;
    bif.lsu_do_load      = ld;
    bif.lsu_do_store     = st;
    bif.lsu_store_data   = wd;
    bif.lsu_store_mask   = wm;
    bif.lsu_prev_stalled = 1'b0;
    lat = -1; req_cyc = 0; stall_cyc = 0; stable = 1'b1; pending = 0; done = 1'b0;
    odata = '0; ofault = 1'b0; obs = '0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      bif.bus_ready      = 1'b0;
      bif.bus_resp_valid = 1'b0;
      bif.bus_resp_err   = 1'b0;
      bif.bus_resp_data  = '0;
      if (!bif.lsu_stall_next) begin
        lat = k; odata = bif.lsu_load_data; ofault = bif.lsu_access_fault;
        stall_cyc = 1; done = 1'b1;
        bif.lsu_prev_stalled = 1'b1;
      end else if (bif.bus_req) begin
        if (req_cyc == 0)
          obs = '{we: bif.bus_we, addr: bif.bus_addr, wdata: bif.bus_wdata, wmask: bif.bus_wmask};
        else if (obs != {bif.bus_we, bif.bus_addr, bif.bus_wdata, bif.bus_wmask})
          stable = 1'b0;
        req_cyc++;
        if (req_cyc > rdy_dly) begin
          bif.bus_ready = 1'b1;
          if (rsp_dly == 0) begin
            bif.bus_resp_valid = 1'b1; bif.bus_resp_err = err; bif.bus_resp_data = rdata;
          end else pending = rsp_dly;
        end
      end else if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          bif.bus_resp_valid = 1'b1; bif.bus_resp_err = err; bif.bus_resp_data = rdata;
        end
      end
    end
    if (done) begin
      @(negedge clk);
      if (!bif.lsu_stall_next) stall_cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bif.lsu_stall_next !== 1'b1) begin
      errors++; $display("FAIL reset_stall: got %b expected 1", bif.lsu_stall_next);
    end
    checks++;
    if (bif.bus_req !== 1'b0) begin
      errors++; $display("FAIL reset_bus_req: got %b expected 0", bif.bus_req);
    end
    checks++;
    if ({bif.lsu_access_fault, bif.lsu_load_data, bif.bus_we, bif.bus_addr, bif.bus_wdata, bif.bus_wmask} !== '0) begin
      errors++; $display("FAIL reset_regs: got fault=%b data=%h we=%b addr=%h wdata=%h wmask=%h expected all 0",
                         bif.lsu_access_fault, bif.lsu_load_data, bif.bus_we, bif.bus_addr, bif.bus_wdata, bif.bus_wmask);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load;
    int lat, rq, sc; logic [XLEN-1:0] d; logic f; bit stb; bus_req_t o; exp_t e;
    push_exp(16'h0010, 1'b0, 8'hFF, 0, 1, 1'b0, 64'hDEADBEEF_01234567);
    run_req(16'h0010, 1'b1, 1'b0, '0, 8'hFF, 0, 1, 1'b0, 64'hDEADBEEF_01234567, lat, d, f, rq, sc, stb, o);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL load_latency: got %0d expected %0d", lat, e.lat); end
    checks++; if (d !== e.data) begin errors++; $display("FAIL load_data: got %h expected %h", d, e.data); end
    checks++; if (f !== e.fault) begin errors++; $display("FAIL load_fault: got %b expected %b", f, e.fault); end
    checks++; if (sc !== 1) begin errors++; $display("FAIL load_stall_width: got %0d expected 1", sc); end
    checks++; if (rq !== e.reqs || o.we !== 1'b0 || o.addr !== 16'h0010) begin
      errors++; $display("FAIL load_bus: got reqs=%0d we=%b addr=%h expected reqs=%0d we=0 addr=0010", rq, o.we, o.addr, e.reqs);
    end
  endtask

  task automatic test_store;
    int lat, rq, sc; logic [XLEN-1:0] d; logic f; bit stb; bus_req_t o; exp_t e;
    logic [AADDR_W-1:0] addr_t[2] = '{16'h0020, 16'h0021};
    logic [XLEN-1:0]    wd_t[2]   = '{64'h0000_0000_AABB_0000, 64'h1122_3344_5566_7788};
    logic [MASK_W-1:0]  wm_t[2]   = '{8'h0C, 8'hFF};
    logic               ld_t[2]   = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      push_exp(addr_t[i], 1'b1, wm_t[i], 4, 1, 1'b0, 64'h5555_AAAA_5555_AAAA);
      run_req(addr_t[i], ld_t[i], 1'b1, wd_t[i], wm_t[i], 4, 1, 1'b0, 64'h5555_AAAA_5555_AAAA,
              lat, d, f, rq, sc, stb, o);
      e = sb.pop_front();
      checks++; if (lat !== e.lat || sc !== 1) begin
        errors++; $display("FAIL store%0d_timing: got lat=%0d width=%0d expected lat=%0d width=1", i, lat, sc, e.lat);
      end
      checks++; if (rq !== e.reqs || !stb) begin
        errors++; $display("FAIL store%0d_req_hold: got cycles=%0d stable=%b expected cycles=%0d stable=1", i, rq, stb, e.reqs);
      end
      checks++; if (o !== bus_req_t'({1'b1, addr_t[i], wd_t[i], wm_t[i]})) begin
        errors++; $display("FAIL store%0d_bus: got we=%b addr=%h wdata=%h wmask=%h expected we=1 addr=%h wdata=%h wmask=%h",
                           i, o.we, o.addr, o.wdata, o.wmask, addr_t[i], wd_t[i], wm_t[i]);
      end
      checks++; if (d !== e.data || f !== e.fault) begin
        errors++; $display("FAIL store%0d_resp: got data=%h fault=%b expected data=%h fault=%b", i, d, f, e.data, e.fault);
      end
    end
  endtask

  task automatic test_range;
    int lat, rq, sc; logic [XLEN-1:0] d; logic f; bit stb; bus_req_t o; exp_t e;
    logic [AADDR_W-1:0] addr_t[3] = '{16'(PMA_BASE_LINE + PMA_LINES), 16'hFFFF, 16'h0040};
    logic               st_t[3]   = '{1'b0, 1'b1, 1'b1};
    logic [MASK_W-1:0]  wm_t[3]   = '{8'hFF, 8'hFF, 8'h00};
    for (int i = 0; i < 3; i++) begin
      push_exp(addr_t[i], st_t[i], wm_t[i], 0, 1, 1'b0, 64'hCAFE);
      run_req(addr_t[i], !st_t[i], st_t[i], 64'h1234, wm_t[i], 0, 1, 1'b0, 64'hCAFE,
              lat, d, f, rq, sc, stb, o);
      e = sb.pop_front();
      checks++; if (lat !== e.lat || sc !== 1) begin
        errors++; $display("FAIL range%0d_timing: got lat=%0d width=%0d expected lat=%0d width=1", i, lat, sc, e.lat);
      end
      checks++; if (f !== e.fault || d !== e.data) begin
        errors++; $display("FAIL range%0d_resp: got fault=%b data=%h expected fault=%b data=%h", i, f, d, e.fault, e.data);
      end
      checks++; if (rq !== 0) begin
        errors++; $display("FAIL range%0d_no_bus: got %0d bus_req cycles expected 0", i, rq);
      end
    end
  endtask

  task automatic test_bus_err;
    int lat, rq, sc; logic [XLEN-1:0] d; logic f; bit stb; bus_req_t o; exp_t e;
    logic [AADDR_W-1:0] addr_t[3] = '{16'h0030, 16'h0031, 16'h0032};
    logic               err_t[3]  = '{1'b1, 1'b0, 1'b1};
    int                 rsp_t[3]  = '{0, 0, 2};
    for (int i = 0; i < 3; i++) begin
      push_exp(addr_t[i], 1'b0, 8'hFF, 0, rsp_t[i], err_t[i], 64'hFFFF_0000_8888_7777);
      run_req(addr_t[i], 1'b1, 1'b0, '0, 8'hFF, 0, rsp_t[i], err_t[i], 64'hFFFF_0000_8888_7777,
              lat, d, f, rq, sc, stb, o);
      e = sb.pop_front();
      checks++; if (lat !== e.lat || sc !== 1) begin
        errors++; $display("FAIL buserr%0d_timing: got lat=%0d width=%0d expected lat=%0d width=1", i, lat, sc, e.lat);
      end
      checks++; if (f !== e.fault || d !== e.data) begin
        errors++; $display("FAIL buserr%0d_resp: got fault=%b data=%h expected fault=%b data=%h", i, f, d, e.fault, e.data);
      end
    end
  endtask

  task automatic test_reset_mid;
    int lat, rq, sc; logic [XLEN-1:0] d; logic f; bit stb; bus_req_t o; exp_t e;
    bit low_seen;
    // abort while bus_req is up
    bif.lsu_addr = 16'h0010; bif.lsu_do_load = 1'b1; bif.lsu_do_store = 1'b0;
    bif.lsu_store_mask = 8'hFF; bif.lsu_prev_stalled = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (bif.bus_req !== 1'b1) begin errors++; $display("FAIL rst_issue_pre: got bus_req=%b expected 1", bif.bus_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bif.bus_req !== 1'b0 || bif.lsu_stall_next !== 1'b1) begin
      errors++; $display("FAIL rst_issue_async: got bus_req=%b stall=%b expected bus_req=0 stall=1", bif.bus_req, bif.lsu_stall_next);
    end
    bif.lsu_prev_stalled = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    // abort while waiting for the response, then deliver it late
    @(posedge clk); #1;
    bif.lsu_prev_stalled = 1'b0;
    @(negedge clk); @(negedge clk);
    bif.bus_ready = 1'b1;
    @(negedge clk);
    bif.bus_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bif.bus_req !== 1'b0 || bif.lsu_stall_next !== 1'b1) begin
      errors++; $display("FAIL rst_wait: got bus_req=%b stall=%b expected bus_req=0 stall=1", bif.bus_req, bif.lsu_stall_next);
    end
    bif.lsu_prev_stalled = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    bif.bus_resp_valid = 1'b1; bif.bus_resp_err = 1'b1; bif.bus_resp_data = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    bif.bus_resp_valid = 1'b0; bif.bus_resp_err = 1'b0; bif.bus_resp_data = '0;
    low_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bif.lsu_stall_next !== 1'b1) low_seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (low_seen || bif.lsu_access_fault !== 1'b0 || bif.lsu_load_data !== '0) begin
      errors++; $display("FAIL rst_late_resp: got stall_low=%b fault=%b data=%h expected stall_low=0 fault=0 data=0",
                         low_seen, bif.lsu_access_fault, bif.lsu_load_data);
    end
    @(posedge clk); #1;
    push_exp(16'h0010, 1'b0, 8'hFF, 0, 1, 1'b0, 64'h0F0E_0D0C_0B0A_0908);
    run_req(16'h0010, 1'b1, 1'b0, '0, 8'hFF, 0, 1, 1'b0, 64'h0F0E_0D0C_0B0A_0908, lat, d, f, rq, sc, stb, o);
    e = sb.pop_front();
    checks++; if (lat !== e.lat || d !== e.data || f !== e.fault) begin
      errors++; $display("FAIL rst_recover: got lat=%0d data=%h fault=%b expected lat=%0d data=%h fault=%b",
                         lat, d, f, e.lat, e.data, e.fault);
    end
  endtask

  task automatic test_back_to_back;
    int lat, rq, sc; logic [XLEN-1:0] d; logic f; bit stb; bus_req_t o; exp_t e;
    logic [AADDR_W-1:0] a; logic [XLEN-1:0] rd; int rdy, rsp;
    for (int i = 0; i < 6; i++) begin
      a   = AADDR_W'($urandom_range(PMA_LINES - 1, 0));
      rd  = {$urandom, $urandom};
      rdy = $urandom_range(2, 0);
      rsp = $urandom_range(2, 0);
      push_exp(a, 1'b0, 8'hFF, rdy, rsp, 1'b0, rd);
      run_req(a, 1'b1, 1'b0, '0, 8'hFF, rdy, rsp, 1'b0, rd, lat, d, f, rq, sc, stb, o);
      e = sb.pop_front();
      checks++; if (lat !== e.lat || d !== e.data || f !== e.fault || sc !== 1 || o.addr !== a) begin
        errors++; $display("FAIL b2b%0d: got lat=%0d data=%h fault=%b width=%0d addr=%h expected lat=%0d data=%h fault=%b width=1 addr=%h",
                           i, lat, d, f, sc, o.addr, e.lat, e.data, e.fault, a);
      end
    end
  endtask

  initial begin
    bif.lsu_prev_stalled = 1'b1;
    bif.lsu_addr         = '0;
    bif.lsu_do_load      = 1'b0;
    bif.lsu_do_store     = 1'b0;
    bif.lsu_store_data   = '0;
    bif.lsu_store_mask   = '0;
    bif.bus_ready        = 1'b0;
    bif.bus_resp_valid   = 1'b0;
    bif.bus_resp_err     = 1'b0;
    bif.bus_resp_data    = '0;
    test_reset();
    test_load();
    test_store();
    test_range();
    test_bus_err();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
